// File: rtl/uart_cmd_assembler_pkg.sv
// Shared types and helpers for the UART command assembler.
// Optional checksum byte support is enabled by defining UART_CMD_CHKSUM_EN.
package uart_cmd_pkg;

    localparam int MAX_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CHK   = 2'd2
    } state_e;

    // Expected checksum byte: inverted 8-bit sum of the low nbytes payload bytes.
    function automatic logic [7:0] calc_chksum(input logic [8*MAX_BYTES-1:0] payload,
                                               input int unsigned nbytes);
        logic [7:0] sum;
        sum = 8'h00;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < int'(nbytes)) begin
                sum = sum + payload[8*i +: 8];
            end
        end
        return ~sum;
    endfunction

endpackage

// File: rtl/uart_cmd_assembler_if.sv
// Byte-in / command-out handshake bundle for the UART command assembler.
// slave: the assembler's view; master: the UART receiver + command processor side.
interface uart_cmd_assembler_if #(
    parameter int BYTES = 2
);
    logic [7:0]         rx_data;
    logic               rx_rdy;
    logic               clr_rdy;
    logic [8*BYTES-1:0] cmd;
    logic               cmd_rdy;
    logic               clr_cmd_rdy;
    logic               overrun;
    logic               timeout;
    logic               chk_err;

    modport slave (
        input  rx_data, rx_rdy, clr_cmd_rdy,
        output clr_rdy, cmd, cmd_rdy, overrun, timeout, chk_err
    );

    modport master (
        output rx_data, rx_rdy, clr_cmd_rdy,
        input  clr_rdy, cmd, cmd_rdy, overrun, timeout, chk_err
    );
endinterface

// File: rtl/uart_cmd_assembler_byte_timeout_cnt.sv
// Inter-byte idle counter: expire_o fires on the TIMEOUT_CYC-th consecutive
// enabled cycle without clr_i. TIMEOUT_CYC=0 disables it entirely.
module byte_timeout_cnt #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, clr_i, en_i};
            assign expire_o = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CYC + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          hit;

            // Count idle cycles; an accept (clr_i) always wins over expiry.
            always_comb begin
                cnt_d = cnt_q;
                hit   = 1'b0;
                if (clr_i || !en_i) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    hit   = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Counter register.
            always_ff @(posedge clk) begin
                if (rst) cnt_q <= '0;
                else     cnt_q <= cnt_d;
            end

            assign expire_o = hit;
        end
    endgenerate
endmodule

// File: rtl/uart_cmd_assembler.sv
// Collects BYTES UART bytes (MSB first) into a double-buffered command word.
// Define UART_CMD_CHKSUM_EN to require a trailing inverted-sum checksum byte.
module uart_cmd_assembler
    import uart_cmd_pkg::*;
#(
    parameter int BYTES       = 2,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_cmd_assembler_if.slave  bus
);
    localparam int W  = 8 * BYTES;
    localparam int CW = $clog2(BYTES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(BYTES);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [W-1:0]  shift_q, shift_d;
    logic [W-1:0]  cmd_q, cmd_d;
    logic [W-1:0]  word_new;
    logic [W+7:0]  shift_ext;
    logic          rdy_q, rdy_d;
    logic          ovr_q, ovr_d;
    logic          tmo_q, tmo_d;
    logic          accept, expire, complete;
`ifdef UART_CMD_CHKSUM_EN
    logic          cerr_q, cerr_d;
`endif

    // The assembler never stalls the receiver.
    assign accept      = bus.rx_rdy;
    assign bus.clr_rdy = accept;
    assign shift_ext   = {shift_q, bus.rx_data};
    assign cnt_inc     = cnt_q + 1'b1;

    byte_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (accept),
        .en_i     (state_q != IDLE),
        .expire_o (expire)
    );

    // Next-state, shift register and completion decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        word_new = shift_ext[W-1:0];
        complete = 1'b0;
        tmo_d    = 1'b0;
`ifdef UART_CMD_CHKSUM_EN
        cerr_d   = 1'b0;
`endif
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    shift_d = shift_ext[W-1:0];
                    if (cnt_inc == LAST_CNT) begin
                        cnt_d = '0;
`ifdef UART_CMD_CHKSUM_EN
                        state_d = CHK;
`else
                        complete = 1'b1;
                        state_d  = IDLE;
`endif
                    end else begin
                        cnt_d   = cnt_inc;
                        state_d = ACCUM;
                    end
                end else if (expire) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    shift_d = '0;
                    tmo_d   = 1'b1;
                end
            end
`ifdef UART_CMD_CHKSUM_EN
            CHK: begin
                word_new = shift_q;
                if (accept) begin
                    state_d = IDLE;
                    if (bus.rx_data == calc_chksum((8*MAX_BYTES)'(shift_q), BYTES))
                        complete = 1'b1;
                    else
                        cerr_d = 1'b1;
                end else if (expire) begin
                    state_d = IDLE;
                    shift_d = '0;
                    tmo_d   = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        cmd_d = complete ? word_new : cmd_q;
        rdy_d = complete ? 1'b1 : (bus.clr_cmd_rdy ? 1'b0 : rdy_q);
        ovr_d = complete && rdy_q && !bus.clr_cmd_rdy;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            cmd_q   <= '0;
            rdy_q   <= 1'b0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            cmd_q   <= cmd_d;
            rdy_q   <= rdy_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef UART_CMD_CHKSUM_EN
    // Checksum error pulse register.
    always_ff @(posedge clk) begin
        if (rst) cerr_q <= 1'b0;
        else     cerr_q <= cerr_d;
    end
    assign bus.chk_err = cerr_q;
`else
    assign bus.chk_err = 1'b0;
`endif

    assign bus.cmd     = cmd_q;
    assign bus.cmd_rdy = rdy_q;
    assign bus.overrun = ovr_q;
    assign bus.timeout = tmo_q;
endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler: three instances (BYTES=2/4/1),
// expected command words queued at stimulus time and popped on completion.
module tb_uart_cmd_assembler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_assembler_if #(.BYTES(2)) bus2 ();
    uart_cmd_assembler_if #(.BYTES(4)) bus4 ();
    uart_cmd_assembler_if #(.BYTES(1)) bus1 ();

    uart_cmd_assembler #(.BYTES(2), .TIMEOUT_CYC(100)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    uart_cmd_assembler #(.BYTES(4))                    dut4 (.clk(clk), .rst(rst), .bus(bus4));
    uart_cmd_assembler #(.BYTES(1), .TIMEOUT_CYC(0))   dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int vectors = 0;
    int errors  = 0;
    int ovr_cnt = 0;
    int tmo_cnt = 0;
    int cerr_cnt = 0;
    logic [63:0] exp_q[$];

    // Pulse counters for the BYTES=2 instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus2.overrun === 1'b1) ovr_cnt++;
        if (bus2.timeout === 1'b1) tmo_cnt++;
        if (bus2.chk_err === 1'b1) cerr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic rdy, input logic [7:0] data, input logic ack);
        case (d)
            0: begin bus2.rx_rdy = rdy; bus2.rx_data = data; bus2.clr_cmd_rdy = ack; end
            1: begin bus4.rx_rdy = rdy; bus4.rx_data = data; bus4.clr_cmd_rdy = ack; end
            default: begin bus1.rx_rdy = rdy; bus1.rx_data = data; bus1.clr_cmd_rdy = ack; end
        endcase
    endtask

    function automatic logic [63:0] f_cmd(input int d);
        case (d)
            0: return 64'(bus2.cmd);
            1: return 64'(bus4.cmd);
            default: return 64'(bus1.cmd);
        endcase
    endfunction

    // {clr_rdy, cmd_rdy, overrun, timeout, chk_err}
    function automatic logic [4:0] f_flags(input int d);
        case (d)
            0: return {bus2.clr_rdy, bus2.cmd_rdy, bus2.overrun, bus2.timeout, bus2.chk_err};
            1: return {bus4.clr_rdy, bus4.cmd_rdy, bus4.overrun, bus4.timeout, bus4.chk_err};
            default: return {bus1.clr_rdy, bus1.cmd_rdy, bus1.overrun, bus1.timeout, bus1.chk_err};
        endcase
    endfunction

    function automatic logic [7:0] tb_chksum(input logic [63:0] w, input int nb);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < nb; i++) s = s + w[8*i +: 8];
        return ~s;
    endfunction

    function automatic logic f_rdy(input int d);
        logic [4:0] f;
        f = f_flags(d);
        return f[3];
    endfunction

    task automatic send_byte(input int d, input logic [7:0] b, input logic ack);
        logic [4:0] f;
        drive(d, 1'b1, b, ack);
        #1;
        f = f_flags(d);
        chk_eq("clr_rdy_on_byte", {63'd0, f[4]}, 64'd1);
        tick();
        drive(d, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic ack(input int d);
        drive(d, 1'b0, 8'h00, 1'b1);
        tick();
        drive(d, 1'b0, 8'h00, 1'b0);
    endtask

    // Send a full command (plus checksum byte when enabled) and check the
    // completed word against the scoreboard one clock after the last accept.
    task automatic send_cmd(input int d, input logic [63:0] word, input int nb,
                            input bit ack_last, input int gap);
        bit ack_pay;
`ifdef UART_CMD_CHKSUM_EN
        ack_pay = 1'b0;
`else
        ack_pay = ack_last;
`endif
        exp_q.push_back(word);
        for (int i = 0; i < nb; i++) begin
            if (i == nb - 1) repeat (gap) tick();
            send_byte(d, word[8*(nb-1-i) +: 8], (i == nb - 1) ? ack_pay : 1'b0);
        end
`ifdef UART_CMD_CHKSUM_EN
        send_byte(d, tb_chksum(word, nb), ack_last);
`endif
        chk_eq("cmd_rdy_after_cmd", {63'd0, f_rdy(d)}, 64'd1);
        chk_eq("cmd_word", f_cmd(d), exp_q.pop_front());
    endtask

    initial begin
        int base;
        logic [4:0] f;
        bus2.rx_rdy = 0; bus2.rx_data = 0; bus2.clr_cmd_rdy = 0;
        bus4.rx_rdy = 0; bus4.rx_data = 0; bus4.clr_cmd_rdy = 0;
        bus1.rx_rdy = 0; bus1.rx_data = 0; bus1.clr_cmd_rdy = 0;

        // Reset state of all instances.
        rst = 1'b1;
        tick(); tick();
        for (int d = 0; d < 3; d++) begin
            chk_eq("reset_cmd", f_cmd(d), 64'd0);
            chk_eq("reset_flags", {59'd0, f_flags(d)}, 64'd0);
        end
        rst = 1'b0;
        tick();

        // Basic two-byte command, sticky cmd_rdy, acknowledge.
        exp_q.push_back(64'hA53C);
        send_byte(0, 8'hA5, 1'b0);
        chk_eq("rdy_after_first_byte", {63'd0, f_rdy(0)}, 64'd0);
        send_byte(0, 8'h3C, 1'b0);
`ifdef UART_CMD_CHKSUM_EN
        chk_eq("rdy_before_chk", {63'd0, f_rdy(0)}, 64'd0);
        send_byte(0, 8'h1E, 1'b0);
`endif
        chk_eq("basic_rdy", {63'd0, f_rdy(0)}, 64'd1);
        chk_eq("basic_cmd", f_cmd(0), exp_q.pop_front());
        f = f_flags(0);
        chk_eq("clr_rdy_idle", {63'd0, f[4]}, 64'd0);
        tick();
        chk_eq("rdy_sticky", {63'd0, f_rdy(0)}, 64'd1);
        ack(0);
        chk_eq("rdy_cleared", {63'd0, f_rdy(0)}, 64'd0);
        chk_eq("cmd_holds_after_ack", f_cmd(0), 64'hA53C);

        // Inter-byte timeout: 100 idle clocks after the first byte.
        base = tmo_cnt;
        send_byte(0, 8'h12, 1'b0);
        repeat (99) tick();
        chk_eq("no_early_timeout", 64'(tmo_cnt - base), 64'd0);
        tick();
        f = f_flags(0);
        chk_eq("timeout_pulse", {63'd0, f[1]}, 64'd1);
        chk_eq("timeout_no_rdy", {63'd0, f_rdy(0)}, 64'd0);
        tick();
        f = f_flags(0);
        chk_eq("timeout_one_cycle", {63'd0, f[1]}, 64'd0);
        send_cmd(0, 64'h3456, 2, 1'b0, 0);
        ack(0);

        // Accept on the would-be expiry cycle wins.
        base = tmo_cnt;
        send_cmd(0, 64'h1234, 2, 1'b0, 99);
        tick();
        chk_eq("accept_beats_timeout", 64'(tmo_cnt - base), 64'd0);
        ack(0);

        // Overrun: second command with no ack in between.
        base = ovr_cnt;
        send_cmd(0, 64'h1111, 2, 1'b0, 0);
        send_cmd(0, 64'h2222, 2, 1'b0, 0);
        tick(); tick();
        chk_eq("overrun_once", 64'(ovr_cnt - base), 64'd1);
        chk_eq("overrun_rdy_kept", {63'd0, f_rdy(0)}, 64'd1);

        // Completion coinciding with acknowledge: no overrun, rdy stays.
        base = ovr_cnt;
        send_cmd(0, 64'h3344, 2, 1'b1, 0);
        tick(); tick();
        chk_eq("ack_coincide_no_overrun", 64'(ovr_cnt - base), 64'd0);
        chk_eq("ack_coincide_rdy", {63'd0, f_rdy(0)}, 64'd1);
        chk_eq("ack_coincide_cmd", f_cmd(0), 64'h3344);

`ifdef UART_CMD_CHKSUM_EN
        // Checksum mismatch leaves the pending command untouched.
        ack(0);
        send_cmd(0, 64'hA53C, 2, 1'b0, 0);
        base = cerr_cnt;
        send_byte(0, 8'hA5, 1'b0);
        send_byte(0, 8'h3C, 1'b0);
        send_byte(0, 8'h1F, 1'b0);
        tick();
        chk_eq("chk_err_once", 64'(cerr_cnt - base), 64'd1);
        chk_eq("chk_err_cmd_kept", f_cmd(0), 64'hA53C);
        chk_eq("chk_err_rdy_kept", {63'd0, f_rdy(0)}, 64'd1);
`endif

        // BYTES=4: reset mid-command discards the partial bytes.
        send_byte(1, 8'hDE, 1'b0);
        send_byte(1, 8'hAD, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_eq("midreset_rdy", {63'd0, f_rdy(1)}, 64'd0);
        chk_eq("midreset_other_cmd", f_cmd(0), 64'd0);
        send_cmd(1, 64'hBEEF0102, 4, 1'b0, 0);

        // BYTES=1: single-byte command, ack clears rdy, cmd holds.
        send_cmd(2, 64'h7F, 1, 1'b0, 0);
        ack(2);
        chk_eq("b1_rdy_cleared", {63'd0, f_rdy(2)}, 64'd0);
        chk_eq("b1_cmd_holds", f_cmd(2), 64'h7F);

        chk_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/uart_cmd_assembler.md
Name: uart_cmd_assembler

Overview:
- Parametrised successor to the two-byte UART command wrapper.
- Collects BYTES consecutive received bytes, MSB first, into one command word and hands it to the command processor with a cmd_rdy/clr_cmd_rdy handshake.
- Adds double buffering, an inter-byte timeout, an overrun flag and an optional checksum byte.
- Sits between the UART receiver byte interface (rx_data/rx_rdy/clr_rdy) and the maze-runner command processor.

Parameters:
- BYTES, 2, payload bytes per command; legal range 1..8; cmd width is 8*BYTES.
- TIMEOUT_CYC, 1_000_000, idle clocks allowed between bytes of one command; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rx_data  input  8  byte from UART receiver
- rx_rdy  input  1  receiver holds a valid byte (level, held until clr_rdy)
- clr_rdy  output  1  one-cycle pulse consuming rx_data
- cmd  output  8*BYTES  assembled command; first received byte in the MS byte
- cmd_rdy  output  1  cmd valid; sticky until cleared
- clr_cmd_rdy  input  1  consumer acknowledge
- overrun  output  1  one-cycle pulse: unacknowledged cmd overwritten
- timeout  output  1  one-cycle pulse: partial command discarded
- chk_err  output  1  one-cycle pulse: checksum mismatch (tied 0 without macro)

Behaviour:
- One clock; reset is synchronous and active-high. rst sampled high: state=IDLE, byte_cnt=0, shift register=0, cmd=0, cmd_rdy=0, all pulses 0, timeout counter=0. Reset mid-command discards the partial command.
- clr_rdy is combinational: asserted in any cycle where rx_rdy=1 and the FSM accepts the byte. The FSM accepts in every state, so clr_rdy equals rx_rdy.
- Byte accept: shift_reg <= {shift_reg[8*BYTES-9:0], rx_data}; byte_cnt++; timeout counter cleared.
- FSM states IDLE, ACCUM, CHK (CHK only with the macro).
  - IDLE: on accept go to ACCUM, or complete immediately if BYTES=1.
  - ACCUM: on the accept that makes byte_cnt==BYTES, complete, or go to CHK with the macro.
  - CHK: on accept, complete or raise chk_err, then return to IDLE.
- Complete: on the cycle after the last accept, cmd <= assembled word, cmd_rdy <= 1, FSM to IDLE, byte_cnt <= 0. Latency from last-byte accept to cmd_rdy is one clock.
- cmd is a holding register separate from the shift register. Accumulation of the next command proceeds while cmd_rdy=1.
- clr_cmd_rdy=1 clears cmd_rdy next clock; cmd holds its value.
- Completion while cmd_rdy=1 and clr_cmd_rdy=0: cmd overwritten with the newer word, cmd_rdy stays 1, overrun pulses 1 cycle.
- Completion coinciding with clr_cmd_rdy=1: new cmd loaded, cmd_rdy stays 1, no overrun.
- Timeout, active only in ACCUM/CHK and only when TIMEOUT_CYC>0:
  - The counter increments on each non-accept cycle.
  - When the count reaches TIMEOUT_CYC-1 without an accept: discard the partial command, byte_cnt=0, FSM to IDLE, timeout pulses one cycle.
  - An accept on the same cycle as expiry wins: no timeout.
- Counter width is $clog2(TIMEOUT_CYC+1). byte_cnt width is $clog2(BYTES+1).

Optional Feature:
- Macro UART_CMD_CHKSUM_EN.
- Defined: one extra byte follows the payload. Valid when chk == ~(sum of payload bytes mod 256).
  - Match: complete as normal.
  - Mismatch: cmd and cmd_rdy unchanged, chk_err pulses, FSM to IDLE.
- Undefined: no CHK state, BYTES bytes per command, chk_err tied 0.

Decomposition:
- Package uart_cmd_pkg:
  - state enum (IDLE, ACCUM, CHK)
  - function for checksum compute
  - localparam MAX_BYTES=8
- One sub-module, byte_timeout_cnt: parametrised TIMEOUT_CYC, inputs clr/en, output expire pulse.

Test Plan:
- BYTES=2; rx_rdy with 0xA5, then 0x3C → clr_rdy pulses per byte; cmd=0xA53C, cmd_rdy=1 one clock after second accept.
- TIMEOUT_CYC=100; send 0x12, idle 100 clocks → timeout pulse, cmd_rdy stays 0; then send 0x34, 0x56 → cmd=0x3456.
- Send 0x1111 with no ack, then 0x2222 → cmd=0x2222, overrun pulses once; repeat with clr_cmd_rdy on the completion cycle → no overrun, cmd_rdy=1.
- BYTES=4; send 0xDE, 0xAD, rst for 1 clock, then 0xBE, 0xEF, 0x01, 0x02 → cmd=0xBEEF0102 only.
- UART_CMD_CHKSUM_EN, BYTES=2; send 0xA5, 0x3C, 0x1E → cmd_rdy, cmd=0xA53C; send 0xA5, 0x3C, 0x1F → chk_err, cmd_rdy unchanged.
- BYTES=1; send 0x7F → cmd=0x7F one clock later; clr_cmd_rdy → cmd_rdy=0 next clock, cmd holds 0x7F.
